// File: rtl/omsp_sm_slot_ctrl.sv
// Protected-module slot controller: owns slot enable bits/IDs, serialises create/destroy, tracks executing SM ID.
// Latency: create done NB_SMS+1 cycles after accept (fixed, one slot checked per cycle); destroy done 1 cycle after accept.
// Backpressure: req_ready is high only in IDLE; req_valid seen in any other state is ignored.
module omsp_sm_slot_ctrl #(
   parameter int NB_SMS   = 4,
   parameter int ID_WIDTH = 16,
   localparam int IDX_W   = (NB_SMS > 1) ? $clog2(NB_SMS) : 1
) (
   input  logic                mclk,
   input  logic                puc_rst,
   input  logic                req_valid,
   input  logic                req_enable,
   output logic                req_ready,
   output logic [IDX_W-1:0]    check_idx,
   output logic                check_en,
   input  logic                check_overlap,
   input  logic [NB_SMS-1:0]   slot_executing,
   input  logic                handling_irq,
   input  logic [3:0]          irq_num,
   output logic [NB_SMS-1:0]   slot_update,
   output logic [NB_SMS-1:0]   slot_disable,
   output logic [ID_WIDTH-1:0] assigned_id,
   output logic                done,
   output logic [2:0]          status,
   output logic [NB_SMS-1:0]   slot_enabled,
   output logic [IDX_W:0]      free_count,
   output logic [ID_WIDTH-1:0] sm_current_id,
   output logic [ID_WIDTH-1:0] sm_prev_id,
   output logic                id_exhausted
);

   // IRQ handlers use the top 16 IDs, so SM IDs must stay below this value.
   localparam logic [ID_WIDTH-1:0] IRQ_ID_BASE = {{(ID_WIDTH-4){1'b1}}, 4'b0000};
   localparam logic [IDX_W-1:0]    LAST_IDX    = IDX_W'(NB_SMS - 1);
   localparam logic [2:0] ST_OK   = 3'd0;
   localparam logic [2:0] ST_OVL  = 3'd1;
   localparam logic [2:0] ST_FULL = 3'd2;
   localparam logic [2:0] ST_EXH  = 3'd3;
   localparam logic [2:0] ST_NIS  = 3'd4;

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   state_t              state, next_state;
   logic [IDX_W-1:0]    idx, first_free, ff_nxt, dst_idx;
   logic                ovl_flag, ff_found, ovl_nxt, ff_found_nxt, dst_hit;
   logic [NB_SMS-1:0]   ff_onehot, dst_onehot;
   logic [2:0]          scan_status;
   logic [ID_WIDTH-1:0] next_id, prev_cycle_id;
   logic [ID_WIDTH-1:0] slot_id [NB_SMS];

   // State register.
   always_ff @(posedge mclk) begin
      if (puc_rst) state <= S_IDLE;
      else         state <= next_state;
   end

   // Next-state and handshake/scan-port outputs.
   always_comb begin
      next_state = state;
      req_ready  = 1'b0;
      check_en   = 1'b0;
      check_idx  = idx;
      case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) next_state = req_enable ? S_SCAN : S_DONE;
         end
         S_SCAN: begin
            check_en = 1'b1;
            if (idx == LAST_IDX) next_state = S_DONE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // Scan accumulators including the slot under check this cycle, and the resulting create status.
   always_comb begin
      ovl_nxt      = ovl_flag | (slot_enabled[idx] & check_overlap);
      ff_found_nxt = ff_found | ~slot_enabled[idx];
      ff_nxt       = (!ff_found && !slot_enabled[idx]) ? idx : first_free;
      if (ovl_nxt)                   scan_status = ST_OVL;
      else if (!ff_found_nxt)        scan_status = ST_FULL;
      else if (next_id == IRQ_ID_BASE) scan_status = ST_EXH;
      else                           scan_status = ST_OK;
   end

   // Destroy target: lowest enabled slot that is currently executing.
   always_comb begin
      dst_hit = 1'b0;
      dst_idx = '0;
      for (int i = NB_SMS - 1; i >= 0; i--) begin
         if (slot_executing[i] & slot_enabled[i]) begin
            dst_hit = 1'b1;
            dst_idx = IDX_W'(i);
         end
      end
   end

   // One-hot decodes for the slot pulses.
   always_comb begin
      for (int i = 0; i < NB_SMS; i++) begin
         ff_onehot[i]  = (ff_nxt  == IDX_W'(i));
         dst_onehot[i] = (dst_idx == IDX_W'(i));
      end
   end

   // Currently executing SM ID: IRQ handlers take priority, then the lowest executing enabled slot.
   always_comb begin
      sm_current_id = '0;
      for (int i = NB_SMS - 1; i >= 0; i--) begin
         if (slot_executing[i] & slot_enabled[i]) sm_current_id = slot_id[i];
      end
      if (handling_irq) sm_current_id = IRQ_ID_BASE | {{(ID_WIDTH-4){1'b0}}, irq_num};
   end

   // Free slots derived from the enable bits so the two can never disagree.
   always_comb begin
      free_count = (IDX_W+1)'(NB_SMS);
      for (int i = 0; i < NB_SMS; i++) begin
         if (slot_enabled[i]) free_count = free_count - (IDX_W+1)'(1);
      end
   end

   // Datapath: scan bookkeeping, registered results, slot array, ID allocation and prev-ID tracking.
   always_ff @(posedge mclk) begin
      if (puc_rst) begin
         idx           <= '0;
         first_free    <= '0;
         ovl_flag      <= 1'b0;
         ff_found      <= 1'b0;
         slot_update   <= '0;
         slot_disable  <= '0;
         done          <= 1'b0;
         status        <= ST_OK;
         assigned_id   <= '0;
         slot_enabled  <= '0;
         next_id       <= ID_WIDTH'(1);
         id_exhausted  <= 1'b0;
         prev_cycle_id <= '0;
         sm_prev_id    <= '0;
         for (int i = 0; i < NB_SMS; i++) slot_id[i] <= '0;
      end else begin
         done         <= 1'b0;
         slot_update  <= '0;
         slot_disable <= '0;

         prev_cycle_id <= sm_current_id;
         if (prev_cycle_id != sm_current_id) sm_prev_id <= prev_cycle_id;

         id_exhausted <= id_exhausted | (next_id == IRQ_ID_BASE);

         // Pulses issued in DONE take effect at the end of that cycle.
         for (int i = 0; i < NB_SMS; i++) begin
            if (slot_update[i]) begin
               slot_enabled[i] <= 1'b1;
               slot_id[i]      <= assigned_id;
            end
            if (slot_disable[i]) begin
               slot_enabled[i] <= 1'b0;
               slot_id[i]      <= '0;
            end
         end
         if ((|slot_update) && (next_id != IRQ_ID_BASE)) next_id <= next_id + ID_WIDTH'(1);

         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  if (req_enable) begin
                     idx        <= '0;
                     first_free <= '0;
                     ovl_flag   <= 1'b0;
                     ff_found   <= 1'b0;
                  end else begin
                     done <= 1'b1;
                     if (dst_hit) begin
                        status       <= ST_OK;
                        slot_disable <= dst_onehot;
                     end else begin
                        status <= ST_NIS;
                     end
                  end
               end
            end
            S_SCAN: begin
               ovl_flag   <= ovl_nxt;
               ff_found   <= ff_found_nxt;
               first_free <= ff_nxt;
               idx        <= idx + IDX_W'(1);
               if (idx == LAST_IDX) begin
                  done   <= 1'b1;
                  status <= scan_status;
                  if (scan_status == ST_OK) begin
                     slot_update <= ff_onehot;
                     assigned_id <= next_id;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_omsp_sm_slot_ctrl.sv
// Bench for omsp_sm_slot_ctrl: directed and randomized create/destroy traffic against a slot-table model.
// Uses ID_WIDTH=6 so that ID exhaustion (next_id reaching 48) is reachable in a short run.
// Inputs are driven and outputs sampled 1 time unit after the rising edge or on the falling edge.
module tb_omsp_sm_slot_ctrl;
   localparam int NB  = 4;
   localparam int IDW = 6;
   localparam int BASE = (1 << IDW) - 16;

   logic           mclk = 1'b0;
   logic           puc_rst;
   logic           req_valid, req_enable, req_ready;
   logic [1:0]     check_idx;
   logic           check_en, check_overlap;
   logic [NB-1:0]  slot_executing;
   logic           handling_irq;
   logic [3:0]     irq_num;
   logic [NB-1:0]  slot_update, slot_disable, slot_enabled;
   logic [IDW-1:0] assigned_id, sm_current_id, sm_prev_id;
   logic           done, id_exhausted;
   logic [2:0]     status;
   logic [2:0]     free_count;
   logic [NB-1:0]  ovl_mask;

   int checks = 0;
   int fails  = 0;

   // Model state
   bit m_en [NB];
   int m_id [NB];
   int m_next;
   int m_assigned;

   always #5 mclk = ~mclk;

   // The external comparator reports overlap for the slots flagged in ovl_mask.
   assign check_overlap = check_en & ovl_mask[check_idx];

   omsp_sm_slot_ctrl #(.NB_SMS(NB), .ID_WIDTH(IDW)) dut (
      .mclk(mclk), .puc_rst(puc_rst), .req_valid(req_valid), .req_enable(req_enable),
      .req_ready(req_ready), .check_idx(check_idx), .check_en(check_en),
      .check_overlap(check_overlap), .slot_executing(slot_executing),
      .handling_irq(handling_irq), .irq_num(irq_num), .slot_update(slot_update),
      .slot_disable(slot_disable), .assigned_id(assigned_id), .done(done),
      .status(status), .slot_enabled(slot_enabled), .free_count(free_count),
      .sm_current_id(sm_current_id), .sm_prev_id(sm_prev_id), .id_exhausted(id_exhausted)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [NB-1:0] m_en_vec();
      logic [NB-1:0] v = '0;
      for (int i = 0; i < NB; i++) v[i] = m_en[i];
      return v;
   endfunction

   function automatic int m_free();
      int n = 0;
      for (int i = 0; i < NB; i++) if (!m_en[i]) n++;
      return n;
   endfunction

   function automatic int cur_exp(input bit h, input int n, input logic [NB-1:0] ex);
      if (h) return BASE + n;
      for (int i = 0; i < NB; i++) if (ex[i] && m_en[i]) return m_id[i];
      return 0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NB; i++) begin m_en[i] = 0; m_id[i] = 0; end
      m_next = 1;
      m_assigned = 0;
   endtask

   // Issue one request and check latency, result, slot table and ID allocation against the model.
   task automatic do_req(input bit en, input logic [NB-1:0] ex, input logic [NB-1:0] omask, input bit noise);
      logic [2:0]    es;
      logic [NB-1:0] eu, ed;
      int k, ff, tgt;
      bit ovl;
      eu = '0; ed = '0; ff = -1; tgt = -1; ovl = 0;
      if (en) begin
         for (int i = 0; i < NB; i++) begin
            if (m_en[i] && omask[i]) ovl = 1;
            if (!m_en[i] && ff < 0) ff = i;
         end
         if (ovl)               es = 3'd1;
         else if (ff < 0)       es = 3'd2;
         else if (m_next == BASE) es = 3'd3;
         else begin es = 3'd0; eu = NB'(1 << ff); end
      end else begin
         for (int i = NB - 1; i >= 0; i--) if (ex[i] && m_en[i]) tgt = i;
         if (tgt < 0) es = 3'd4;
         else begin es = 3'd0; ed = NB'(1 << tgt); end
      end

      @(negedge mclk);
      chk("req_ready_idle", req_ready, 1);
      req_valid = 1'b1; req_enable = en; slot_executing = ex; ovl_mask = omask;
      @(posedge mclk); #1;
      // Requests presented while busy must be ignored.
      req_valid = noise; req_enable = 1'($urandom);
      k = 0;
      while (!done && k < 12) begin @(posedge mclk); #1; k++; end
      req_valid = 1'b0;
      chk(en ? "create_latency" : "destroy_latency", k, en ? NB : 0);
      chk("status", status, es);
      chk("slot_update", slot_update, eu);
      chk("slot_disable", slot_disable, ed);
      if (eu != 0) begin m_en[ff] = 1; m_id[ff] = m_next; m_assigned = m_next; m_next++; end
      if (ed != 0) begin m_en[tgt] = 0; m_id[tgt] = 0; end
      chk("assigned_id", assigned_id, m_assigned);
      @(posedge mclk); #1;
      chk("done_one_cycle", done, 0);
      chk("slot_enabled", slot_enabled, m_en_vec());
      chk("free_count", free_count, m_free());
      @(posedge mclk); #1;
      chk("id_exhausted", id_exhausted, m_next == BASE);
   endtask

   initial begin
      puc_rst = 1'b1; req_valid = 1'b0; req_enable = 1'b0; slot_executing = '0;
      handling_irq = 1'b0; irq_num = '0; ovl_mask = '0;
      model_reset();
      repeat (3) @(posedge mclk);
      #1 puc_rst = 1'b0;

      // Reset state
      chk("rst_req_ready", req_ready, 1);
      chk("rst_slot_enabled", slot_enabled, 0);
      chk("rst_free_count", free_count, NB);
      chk("rst_done", done, 0);
      chk("rst_status", status, 0);
      chk("rst_assigned_id", assigned_id, 0);
      chk("rst_prev_id", sm_prev_id, 0);
      chk("rst_cur_id", sm_current_id, 0);
      chk("rst_id_exhausted", id_exhausted, 0);

      // Directed scenario: allocation, overlap, full, destroy and non-reuse of IDs.
      do_req(1, 4'b0000, 4'b0000, 0);
      chk("first_id", assigned_id, 1);
      do_req(1, 4'b0000, 4'b1100, 1);           // overlap flags on disabled slots are ignored
      chk("second_free_count", free_count, 2);
      do_req(1, 4'b0000, 4'b0001, 0);           // overlap with slot 0
      chk("overlap_status", status, 1);
      do_req(1, 4'b0000, 4'b0000, 0);
      chk("id_after_overlap", assigned_id, 3);
      do_req(1, 4'b0000, 4'b0000, 0);
      do_req(1, 4'b0000, 4'b0000, 1);
      chk("full_status", status, 2);
      do_req(0, 4'b0100, 4'b0000, 0);
      chk("destroy_free_count", free_count, 1);
      do_req(1, 4'b0000, 4'b0000, 0);
      chk("fresh_id", assigned_id, 5);
      do_req(0, 4'b0000, 4'b0000, 0);
      chk("not_in_sm_status", status, 4);

      // Current/previous ID across an IRQ excursion from the slot holding ID 2.
      handling_irq = 1'b0; slot_executing = 4'b0010;
      repeat (2) @(posedge mclk); #1;
      chk("cur_id_slot", sm_current_id, cur_exp(0, 0, 4'b0010));
      handling_irq = 1'b1; irq_num = 4'd3; #1;
      chk("cur_id_irq", sm_current_id, BASE + 3);
      repeat (2) @(posedge mclk); #1;
      chk("prev_id_before_irq", sm_prev_id, 2);
      handling_irq = 1'b0;
      repeat (2) @(posedge mclk); #1;
      chk("prev_id_after_irq", sm_prev_id, BASE + 3);

      // Reset in the middle of a create that would otherwise succeed.
      do_req(0, 4'b0001, 4'b0000, 0);
      @(negedge mclk);
      req_valid = 1'b1; req_enable = 1'b1; ovl_mask = '0; slot_executing = '0;
      @(posedge mclk); #1 req_valid = 1'b0;
      @(posedge mclk); #1 puc_rst = 1'b1;
      @(posedge mclk); #1 puc_rst = 1'b0;
      model_reset();
      chk("midrst_req_ready", req_ready, 1);
      chk("midrst_slot_enabled", slot_enabled, 0);
      chk("midrst_free_count", free_count, NB);
      chk("midrst_assigned", assigned_id, 0);
      for (int c = 0; c < 6; c++) begin
         chk("midrst_no_done", done, 0);
         chk("midrst_no_update", slot_update, 0);
         @(posedge mclk); #1;
      end

      // Randomized traffic with current-ID spot checks.
      for (int n = 0; n < 100; n++) begin
         bit en;
         logic [NB-1:0] ex, om;
         bit h;
         int q;
         en = ($urandom_range(0, 9) < 6);
         ex = NB'($urandom);
         om = ($urandom_range(0, 3) == 0) ? NB'($urandom) : '0;
         do_req(en, ex, om, 1'($urandom));
         h = ($urandom_range(0, 3) == 0);
         q = $urandom_range(0, 15);
         ex = NB'($urandom);
         handling_irq = h; irq_num = 4'(q); slot_executing = ex; #1;
         chk("cur_id_rand", sm_current_id, cur_exp(h, q, ex));
      end
      handling_irq = 1'b0;

      // Drive the ID allocator to exhaustion.
      for (int n = 0; n < 200 && m_next != BASE; n++) begin
         if (m_free() == 0) do_req(0, 4'b0001, 4'b0000, 0);
         else               do_req(1, 4'b0000, 4'b0000, 0);
      end
      if (m_free() == 0) do_req(0, 4'b0001, 4'b0000, 0);
      chk("exh_id_exhausted", id_exhausted, 1);
      do_req(1, 4'b0000, 4'b0000, 0);
      chk("exh_status", status, 3);
      chk("exh_last_id", assigned_id, BASE - 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
